// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 SCCB power-up configuration block.
package ov7670_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_BITS,
    ST_STOP,
    ST_GAP,
    ST_DELAY,
    ST_FINISH
  } cfg_state_e;

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  localparam int SCCB_FRAME_BITS = 27;

  // 3-phase write frame; each phase ends with a don't-care bit sent as released (1).
  function automatic logic [SCCB_FRAME_BITS-1:0] sccb_frame(input logic [7:0] dev,
                                                            input logic [15:0] entry);
    return {dev, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
  endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Registered register table: {reg_addr, data} per entry, one cycle from addr to entry.
module ov7670_reg_rom
  import ov7670_cfg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int TABLE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [15:0]       entry
);

  logic [7:0]  a8;
  logic [15:0] entry_d;

  assign a8 = 8'(addr);

  // TABLE 0 is the sensor bring-up table; 1..3 are short tables for bench bring-up.
  always_comb begin
    entry_d = END_MARK;
    case (TABLE)
      1: begin
        case (a8)
          8'd0:    entry_d = 16'h1280;
          default: entry_d = END_MARK;
        endcase
      end
      2: begin
        case (a8)
          8'd0:    entry_d = 16'h1280;
          8'd1:    entry_d = DELAY_MARK;
          8'd2:    entry_d = 16'h1204;
          default: entry_d = END_MARK;
        endcase
      end
      3: entry_d = {8'h20 + a8, ~a8};
      default: begin
        case (a8)
          8'd0:    entry_d = 16'h1280;  // COM7 soft reset
          8'd1:    entry_d = DELAY_MARK;
          8'd2:    entry_d = 16'h1204;  // COM7: RGB output
          8'd3:    entry_d = 16'h1101;  // CLKRC: prescale by 2
          8'd4:    entry_d = 16'h0C00;  // COM3
          8'd5:    entry_d = 16'h3E00;  // COM14
          8'd6:    entry_d = 16'h40D0;  // COM15: RGB565, full range
          8'd7:    entry_d = 16'h3A04;  // TSLB
          8'd8:    entry_d = 16'h8C00;  // RGB444 off
          default: entry_d = END_MARK;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= '0;
    end else begin
      entry <= entry_d;
    end
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// Walks the register table after a start pulse and writes each entry as an SCCB 3-phase write.
module ov7670_sccb_config
  import ov7670_cfg_pkg::*;
#(
  parameter int         CLK_DIV      = 250,
  parameter logic [7:0] DEV_ADDR     = 8'h42,
  parameter int         DELAY_CYCLES = 1_000_000,
  parameter int         ROM_AW       = 8,
  parameter int         ROM_SEL      = 0
) (
  input  logic              clk100,
  input  logic              reset_n,
  // start is a single-cycle request honoured only in IDLE; there is no ready/ack,
  // busy/done report progress as levels.
  input  logic              start,
  output logic              sioc,
  output logic              siod_oe,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] cfg_index,
  output cfg_state_e        dbg_state
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0]     Q_LAST   = QW'(CLK_DIV - 1);
  localparam logic [4:0]        LAST_BIT = 5'(SCCB_FRAME_BITS - 1);
  localparam logic [31:0]       DLY_LAST = 32'(DELAY_CYCLES - 1);
  localparam logic [ROM_AW-1:0] IDX_LAST = '1;

  cfg_state_e                 state_q, state_d;
  logic [QW-1:0]              qcnt_q, qcnt_d;
  logic [1:0]                 qtr_q, qtr_d;
  logic [4:0]                 bit_q, bit_d;
  logic [SCCB_FRAME_BITS-1:0] shift_q, shift_d;
  logic [31:0]                dly_q, dly_d;
  logic [ROM_AW-1:0]          idx_q, idx_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       sioc_q, sioc_d;
  logic                       oe_q, oe_d;

  logic [15:0]   rom_entry;
  logic          tick;
  logic [QW-1:0] qcnt_inc;

  // The ROM is addressed with the next index so the entry is already valid in FETCH.
  ov7670_reg_rom #(
    .ADDR_W (ROM_AW),
    .TABLE  (ROM_SEL)
  ) u_rom (
    .clk   (clk100),
    .rst_n (reset_n),
    .addr  (idx_d),
    .entry (rom_entry)
  );

  assign tick     = (qcnt_q == Q_LAST);
  assign qcnt_inc = tick ? '0 : qcnt_q + QW'(1);

  always_comb begin
    state_d = state_q;
    qcnt_d  = '0;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dly_d   = '0;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sioc_d  = 1'b1;
    oe_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          idx_d   = '0;
        end
      end
      ST_FETCH: begin
        qtr_d = 2'd0;
        bit_d = 5'd0;
        if (rom_entry == END_MARK || idx_q == IDX_LAST) begin
          state_d = ST_FINISH;
        end else if (rom_entry == DELAY_MARK) begin
          state_d = ST_DELAY;
        end else begin
          shift_d = sccb_frame(DEV_ADDR, rom_entry);
          state_d = ST_START;
        end
      end
      ST_START: begin
        qcnt_d = qcnt_inc;
        oe_d   = 1'b1;
        if (tick) begin
          if (qtr_q == 2'd1) begin
            qtr_d   = 2'd0;
            state_d = ST_BITS;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      ST_BITS: begin
        qcnt_d = qcnt_inc;
        sioc_d = qtr_q[1];
        // Hold SIOD for the first cycle of q0 so it only moves once SIOC is already low.
        oe_d   = (qtr_q == 2'd0 && qcnt_q == '0) ? oe_q : ~shift_q[SCCB_FRAME_BITS-1];
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            shift_d = {shift_q[SCCB_FRAME_BITS-2:0], 1'b0};
            if (bit_q == LAST_BIT) begin
              bit_d   = 5'd0;
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end
      end
      ST_STOP: begin
        qcnt_d = qcnt_inc;
        sioc_d = (qtr_q != 2'd0);
        oe_d   = (qtr_q == 2'd0 && qcnt_q == '0) ? oe_q : ~qtr_q[1];
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        qcnt_d = qcnt_inc;
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            state_d = ST_FETCH;
            idx_d   = idx_q + ROM_AW'(1);
          end
        end
      end
      ST_DELAY: begin
        dly_d = dly_q + 32'd1;
        if (dly_q == DLY_LAST) begin
          dly_d   = '0;
          state_d = ST_FETCH;
          idx_d   = idx_q + ROM_AW'(1);
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset releases both bus lines at once; an interrupted write gets no stop condition.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      qcnt_q  <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dly_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sioc_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sioc_q  <= sioc_d;
      oe_q    <= oe_d;
    end
  end

  assign sioc      = sioc_q;
  assign siod_oe   = oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_index = idx_q;
  assign dbg_state = state_q;

endmodule
